// File: rtl/reg_scoreboard_pkg.sv
// Shared types for the issue scoreboard: register address, data word,
// architectural register count and the pending-counter width helper.
package reg_scoreboard_pkg;

    typedef logic [4:0]  RegAddress;
    typedef logic [31:0] Word;

    localparam int REG_COUNT = 1 << $bits(RegAddress);

    function automatic int cnt_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/reg_pending_counter.sv
// Saturating up/down counter of outstanding writes to one register.
// A decrement at zero holds the count and pulses underflow_o.
module reg_pending_counter #(
    parameter int MAX_PENDING = 3,
    parameter int W           = $clog2(MAX_PENDING + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic dec_i,
    output logic nonzero_o,
    output logic full_o,
    output logic one_o,
    output logic underflow_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    localparam logic [W-1:0] MaxCnt = W'(MAX_PENDING);
    localparam logic [W-1:0] OneCnt = W'(1);

    always_comb begin
        count_d     = count_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q != MaxCnt) begin
                count_d = count_q + OneCnt;
            end
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                count_d = count_q - OneCnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign nonzero_o = (count_q != '0);
    assign full_o    = (count_q == MaxCnt);
    assign one_o     = (count_q == OneCnt);

endmodule

// File: rtl/reg_scoreboard.sv
// In-order issue scoreboard; stalls on RAW and pending-write overflow.
// SCOREBOARD_WB_BYPASS_EN lets a same-cycle last writeback clear a RAW stall.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int MAX_PENDING = 3
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      issue_valid,
    input  RegAddress issue_rs1,
    input  RegAddress issue_rs2,
    input  logic      issue_uses_rs1,
    input  logic      issue_uses_rs2,
    input  RegAddress issue_rd,
    input  logic      issue_writes_rd,
    output logic      issue_ready,
    input  logic      wb_valid,
    input  RegAddress wb_rd,
    output logic [31:0] busy,
    output logic      underflow
);

    logic [REG_COUNT-1:0] nonzero;
    logic [REG_COUNT-1:0] full;
    logic [REG_COUNT-1:0] one;
    logic [REG_COUNT-1:0] inc;
    logic [REG_COUNT-1:0] dec;
    logic [REG_COUNT-1:0] uf;

    logic underflow_q;
    logic underflow_d;
    logic haz_rs1;
    logic haz_rs2;
    logic haz_rd;
    logic fire;

    assign nonzero[0] = 1'b0;
    assign full[0]    = 1'b0;
    assign one[0]     = 1'b0;
    assign inc[0]     = 1'b0;
    assign dec[0]     = 1'b0;
    assign uf[0]      = 1'b0;

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_cnt
        assign inc[i] = fire && (issue_rd == RegAddress'(i));
        assign dec[i] = wb_valid && (wb_rd == RegAddress'(i));

        reg_pending_counter #(
            .MAX_PENDING(MAX_PENDING),
            .W          (cnt_width(MAX_PENDING))
        ) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .inc_i      (inc[i]),
            .dec_i      (dec[i]),
            .nonzero_o  (nonzero[i]),
            .full_o     (full[i]),
            .one_o      (one[i]),
            .underflow_o(uf[i])
        );
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    // Last outstanding write retiring now is forwarded to decode.
    logic byp_rs1;
    logic byp_rs2;
    assign byp_rs1 = wb_valid && (wb_rd == issue_rs1) && one[issue_rs1];
    assign byp_rs2 = wb_valid && (wb_rd == issue_rs2) && one[issue_rs2];
`else
    logic byp_rs1;
    logic byp_rs2;
    assign byp_rs1 = 1'b0;
    assign byp_rs2 = 1'b0;
`endif

    assign haz_rs1 = issue_uses_rs1 && (issue_rs1 != '0)
                  && nonzero[issue_rs1] && !byp_rs1;
    assign haz_rs2 = issue_uses_rs2 && (issue_rs2 != '0)
                  && nonzero[issue_rs2] && !byp_rs2;
    assign haz_rd  = issue_writes_rd && (issue_rd != '0) && full[issue_rd];

    assign issue_ready = !(haz_rs1 || haz_rs2 || haz_rd);
    assign fire = issue_valid && issue_ready && issue_writes_rd
               && (issue_rd != '0);

    assign underflow_d = underflow_q || (|uf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign busy      = nonzero;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
// Honours SCOREBOARD_WB_BYPASS_EN for the retire-cycle read check.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    RegAddress   issue_rs1;
    RegAddress   issue_rs2;
    logic        issue_uses_rs1;
    logic        issue_uses_rs2;
    RegAddress   issue_rd;
    logic        issue_writes_rd;
    logic        issue_ready;
    logic        wb_valid;
    RegAddress   wb_rd;
    logic [31:0] busy;
    logic        underflow;

    int n_chk;
    int n_pass;

    reg_scoreboard #(.MAX_PENDING(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_uses_rs1 (issue_uses_rs1),
        .issue_uses_rs2 (issue_uses_rs2),
        .issue_rd       (issue_rd),
        .issue_writes_rd(issue_writes_rd),
        .issue_ready    (issue_ready),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .busy           (busy),
        .underflow      (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid     = 1'b0;
        issue_rs1       = '0;
        issue_rs2       = '0;
        issue_uses_rs1  = 1'b0;
        issue_uses_rs2  = 1'b0;
        issue_rd        = '0;
        issue_writes_rd = 1'b0;
        wb_valid        = 1'b0;
        wb_rd           = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input RegAddress rd);
        idle();
        issue_valid     = 1'b1;
        issue_rd        = rd;
        issue_writes_rd = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        idle();
        reset = 1'b1;
        #1;
        chk("rst_ready_held", {31'd0, issue_ready}, 32'd1);
        step();
        chk("rst_busy", busy, 32'd0);
        chk("rst_underflow", {31'd0, underflow}, 32'd0);
        reset = 1'b0;
        step();

        // Plain issue, then destination shows busy.
        idle();
        issue_valid = 1'b1;
        issue_rs1 = 5'd5; issue_uses_rs1 = 1'b1;
        issue_rs2 = 5'd6; issue_uses_rs2 = 1'b1;
        issue_rd = 5'd7;  issue_writes_rd = 1'b1;
        #1 chk("first_ready", {31'd0, issue_ready}, 32'd1);
        step();
        idle();
        chk("busy_x7", busy, 32'h80);

        // RAW on x7, retire the same cycle.
        issue_valid = 1'b1;
        issue_rs1 = 5'd7; issue_uses_rs1 = 1'b1;
        #1 chk("raw_stall", {31'd0, issue_ready}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd7;
`ifdef SCOREBOARD_WB_BYPASS_EN
        #1 chk("raw_retire_cycle", {31'd0, issue_ready}, 32'd1);
`else
        #1 chk("raw_retire_cycle", {31'd0, issue_ready}, 32'd0);
`endif
        step();
        wb_valid = 1'b0;
        #1 chk("raw_after_retire", {31'd0, issue_ready}, 32'd1);
        chk("busy_clear", busy, 32'd0);
        step();

        // Saturation on x3.
        wr(5'd3);
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("fill_%0d", k), {31'd0, issue_ready}, 32'd1);
            step();
        end
        #1 chk("fourth_stall", {31'd0, issue_ready}, 32'd0);
        chk("busy_x3", busy, 32'h8);
        wb_valid = 1'b1; wb_rd = 5'd3;
        #1 chk("full_retire_cycle", {31'd0, issue_ready}, 32'd0);
        step();
        wb_valid = 1'b0;
        #1 chk("fourth_issues", {31'd0, issue_ready}, 32'd1);
        step();
        #1 chk("full_again", {31'd0, issue_ready}, 32'd0);
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3;
        step();
        // count 2: issue and retire together keep it at 2
        issue_valid = 1'b1;
        #1 chk("coincide_ready", {31'd0, issue_ready}, 32'd1);
        step();
        wb_valid = 1'b0;
        #1 chk("after_coincide", {31'd0, issue_ready}, 32'd1);
        step();
        #1 chk("full_third", {31'd0, issue_ready}, 32'd0);
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3;
        step(); step(); step();
        idle();
        chk("drain_busy", busy, 32'd0);
        chk("drain_no_uf", {31'd0, underflow}, 32'd0);

        // x0 is never tracked, on either side.
        for (int k = 0; k < 3; k++) begin
            idle();
            issue_valid = 1'b1;
            issue_rs1 = 5'd0; issue_uses_rs1 = 1'b1;
            issue_rd = 5'd0;  issue_writes_rd = 1'b1;
            wb_valid = 1'b1;  wb_rd = 5'd0;
            #1 chk($sformatf("x0_ready_%0d", k), {31'd0, issue_ready}, 32'd1);
            step();
            chk($sformatf("x0_busy_%0d", k), busy, 32'd0);
        end
        idle();
        chk("x0_no_uf", {31'd0, underflow}, 32'd0);

        // Underflow is sticky until reset.
        wb_valid = 1'b1; wb_rd = 5'd9;
        step();
        idle();
        chk("uf_set", {31'd0, underflow}, 32'd1);
        step(); step();
        chk("uf_sticky", {31'd0, underflow}, 32'd1);
        chk("uf_busy", busy, 32'd0);
        reset = 1'b1;
        #1 chk("uf_reset", {31'd0, underflow}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // Asynchronous reset with three registers pending.
        wr(5'd1); step();
        wr(5'd2); step();
        wr(5'd3); step();
        idle();
        chk("three_busy", busy, 32'hE);
        issue_valid = 1'b1;
        issue_rs1 = 5'd1; issue_uses_rs1 = 1'b1;
        #1 chk("pre_rst_stall", {31'd0, issue_ready}, 32'd0);
        #1 reset = 1'b1;
        #1 chk("async_busy", busy, 32'd0);
        chk("async_ready", {31'd0, issue_ready}, 32'd1);
        step();
        reset = 1'b0;
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
